// File: rtl/servant_mem_arbiter_n_if.sv
// servant_mem_arbiter_n_if
// Groups the bus signals around the N-port memory arbiter into one bundle.
// Master side (N Wishbone-classic masters, packed per port):
//   m_adr/m_dat/m_sel/m_we/m_cyc  requests, port p at [p*W +: W]
//   m_rdt                         read data broadcast to all masters
//   m_ack/m_err                   per-master completion, one-hot or zero
// Slave side (the single servant_ram port):
//   s_adr/s_dat/s_sel/s_we/s_cyc  request forwarded from the granted master
//   s_rdt/s_ack                   response from the RAM
// Modports: master = the requesting masters, slave = the RAM,
//           arbiter = the arbiter sitting between them.
interface servant_mem_arbiter_n_if #(
  parameter int N_PORTS = 4,
  parameter int AW      = 32,
  parameter int DW      = 32
);
  localparam int SW = DW / 8;

  logic [N_PORTS*AW-1:0] m_adr;
  logic [N_PORTS*DW-1:0] m_dat;
  logic [N_PORTS*SW-1:0] m_sel;
  logic [N_PORTS-1:0]    m_we;
  logic [N_PORTS-1:0]    m_cyc;
  logic [DW-1:0]         m_rdt;
  logic [N_PORTS-1:0]    m_ack;
  logic [N_PORTS-1:0]    m_err;

  logic [AW-1:0]         s_adr;
  logic [DW-1:0]         s_dat;
  logic [SW-1:0]         s_sel;
  logic                  s_we;
  logic                  s_cyc;
  logic [DW-1:0]         s_rdt;
  logic                  s_ack;

  modport master (
    output m_adr, m_dat, m_sel, m_we, m_cyc,
    input  m_rdt, m_ack, m_err
  );

  modport slave (
    input  s_adr, s_dat, s_sel, s_we, s_cyc,
    output s_rdt, s_ack
  );

  modport arbiter (
    input  m_adr, m_dat, m_sel, m_we, m_cyc, s_rdt, s_ack,
    output m_rdt, m_ack, m_err, s_adr, s_dat, s_sel, s_we, s_cyc
  );
endinterface

// File: rtl/servant_mem_arbiter_n.sv
// servant_mem_arbiter_n
// Connects N Wishbone-classic masters to the single servant_ram port.
// Winner is picked in IDLE (fixed priority or round robin), the grant is
// registered and held for the whole transfer. A transfer ends on slave ack
// (normal), on timeout (error pulse to the master) or when the granted
// master drops cyc (silent abort).
// Ports:
//   i_clk    clock
//   i_rst    asynchronous active-high reset
//   bus      arbiter modport: master-side requests/responses and the
//            slave-side request/response of the RAM
//   o_grant  current one-hot grant, zero while idle
module servant_mem_arbiter_n #(
  parameter int N_PORTS = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR      = 1,
  parameter int TIMEOUT = 15
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  servant_mem_arbiter_n_if.arbiter bus,
  output logic [N_PORTS-1:0]       o_grant
);
  localparam int SW = DW / 8;
  localparam int IW = $clog2(N_PORTS);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Counter value seen during the TIMEOUT-th busy cycle (counter starts at 0).
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic [N_PORTS-1:0] grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               win_found;
  logic [IW-1:0]      win_idx;
  int                 scan_idx;
  logic               busy, g_cyc, ack_evt, to_hit;

  // Winner search: round robin starts just after the last completed port,
  // fixed priority always starts at port 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (RR != 0) scan_idx = (int'(last_q) + 1 + k) % N_PORTS;
      else         scan_idx = k;
      if (!win_found && bus.m_cyc[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(scan_idx);
      end
    end
  end

  assign busy    = (state_q == BUSY);
  assign g_cyc   = bus.m_cyc[gidx_q];
  assign ack_evt = busy && g_cyc && bus.s_ack;
  // Ack in the same cycle as the timeout takes precedence.
  assign to_hit  = (TIMEOUT != 0) && busy && g_cyc && !bus.s_ack && (cnt_q == TO_LAST);

  assign bus.s_cyc = busy && g_cyc && !to_hit;
  assign bus.s_we  = busy ? bus.m_we[gidx_q] : 1'b0;
  assign bus.s_adr = busy ? bus.m_adr[gidx_q*AW +: AW] : '0;
  assign bus.s_dat = busy ? bus.m_dat[gidx_q*DW +: DW] : '0;
  assign bus.s_sel = busy ? bus.m_sel[gidx_q*SW +: SW] : '0;
  assign bus.m_rdt = busy ? bus.s_rdt : '0;
  assign bus.m_ack = ack_evt ? grant_q : '0;
  assign bus.m_err = to_hit ? grant_q : '0;
  assign o_grant   = grant_q;

  // Next state. Only normal and error completions move the round-robin
  // pointer; an abort leaves it where it was.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (win_found) begin
          state_d = BUSY;
          grant_d = {{(N_PORTS-1){1'b0}}, 1'b1} << win_idx;
          gidx_d  = win_idx;
        end
      end
      BUSY: begin
        if (ack_evt || to_hit) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end else if (!g_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers; reset leaves the pointer on the last port so port 0
  // is first in line.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(N_PORTS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_servant_mem_arbiter_n.sv
// tb_servant_mem_arbiter_n
// Two arbiters (round robin and fixed priority) share the same master
// stimulus, each with its own 1-cycle-ack RAM model.
module tb_servant_mem_arbiter_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_mute = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  logic [127:0] m_adr = '0;
  logic [127:0] m_dat = '0;
  logic [15:0]  m_sel = '0;
  logic [3:0]   m_we  = '0;
  logic [3:0]   m_cyc = '0;
  logic [3:0]   grant_a, grant_b;

  always #5 clk = ~clk;

  servant_mem_arbiter_n_if #(.N_PORTS(4), .AW(32), .DW(32)) bus_a ();
  servant_mem_arbiter_n_if #(.N_PORTS(4), .AW(32), .DW(32)) bus_b ();

  assign bus_a.m_adr = m_adr;
  assign bus_a.m_dat = m_dat;
  assign bus_a.m_sel = m_sel;
  assign bus_a.m_we  = m_we;
  assign bus_a.m_cyc = m_cyc;
  assign bus_b.m_adr = m_adr;
  assign bus_b.m_dat = m_dat;
  assign bus_b.m_sel = m_sel;
  assign bus_b.m_we  = m_we;
  assign bus_b.m_cyc = m_cyc;

  servant_mem_arbiter_n #(.N_PORTS(4), .AW(32), .DW(32), .RR(1), .TIMEOUT(15)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(bus_a), .o_grant(grant_a));
  servant_mem_arbiter_n #(.N_PORTS(4), .AW(32), .DW(32), .RR(0), .TIMEOUT(15)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(bus_b), .o_grant(grant_b));

  // RAM models: registered ack one cycle after s_cyc, byte-masked writes.
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic        ram_a_ack, ram_b_ack;
  logic [31:0] ram_a_rdt, ram_b_rdt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_a_ack <= 1'b0;
      ram_a_rdt <= '0;
    end else if (bus_a.s_cyc && !ram_a_ack && !ram_mute) begin
      for (int b = 0; b < 4; b++)
        if (bus_a.s_we && bus_a.s_sel[b]) mem_a[8'(bus_a.s_adr >> 2)][b*8 +: 8] <= bus_a.s_dat[b*8 +: 8];
      ram_a_rdt <= mem_a[8'(bus_a.s_adr >> 2)];
      ram_a_ack <= 1'b1;
    end else begin
      ram_a_ack <= 1'b0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_b_ack <= 1'b0;
      ram_b_rdt <= '0;
    end else if (bus_b.s_cyc && !ram_b_ack && !ram_mute) begin
      for (int b = 0; b < 4; b++)
        if (bus_b.s_we && bus_b.s_sel[b]) mem_b[8'(bus_b.s_adr >> 2)][b*8 +: 8] <= bus_b.s_dat[b*8 +: 8];
      ram_b_rdt <= mem_b[8'(bus_b.s_adr >> 2)];
      ram_b_ack <= 1'b1;
    end else begin
      ram_b_ack <= 1'b0;
    end
  end

  assign bus_a.s_ack = ram_a_ack;
  assign bus_a.s_rdt = ram_a_rdt;
  assign bus_b.s_ack = ram_b_ack;
  assign bus_b.s_rdt = ram_b_rdt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
    m_adr[p*32 +: 32] = adr;
    m_dat[p*32 +: 32] = dat;
    m_sel[p*4 +: 4]   = sel;
    m_we[p]           = we;
    m_cyc[p]          = 1'b1;
  endtask

  task automatic clr_req(input int p);
    m_cyc[p] = 1'b0;
    m_we[p]  = 1'b0;
  endtask

  // Waits for an ack on arbiter A; cycles = cycle index of the ack counted
  // from the request cycle (0), or 0 if none arrives in the budget.
  task automatic wait_ack(output logic [3:0] ack_a, output logic [3:0] ack_b,
                          output logic [31:0] rdt_a, output logic [31:0] rdt_b,
                          output int cycles);
    ack_a = '0; ack_b = '0; rdt_a = '0; rdt_b = '0; cycles = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (bus_a.m_ack != 4'b0) begin
        ack_a = bus_a.m_ack; ack_b = bus_b.m_ack;
        rdt_a = bus_a.m_rdt; rdt_b = bus_b.m_rdt;
        cycles = i - 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({grant_a, bus_a.s_cyc, bus_a.s_we, bus_a.s_adr, bus_a.s_dat, bus_a.s_sel,
         bus_a.m_ack, bus_a.m_err, bus_a.m_rdt} !== '0) begin
      fails++; $display("[TB] FAIL reset_outputs_a: got grant=%b s_cyc=%b s_adr=%h m_rdt=%h, expected all 0",
                        grant_a, bus_a.s_cyc, bus_a.s_adr, bus_a.m_rdt);
    end
    checks++;
    if ({grant_b, bus_b.s_cyc, bus_b.s_we, bus_b.s_adr, bus_b.s_dat, bus_b.s_sel,
         bus_b.m_ack, bus_b.m_err, bus_b.m_rdt} !== '0) begin
      fails++; $display("[TB] FAIL reset_outputs_b: got grant=%b s_cyc=%b, expected all 0", grant_b, bus_b.s_cyc);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_full();
    logic [3:0] aa, ab; logic [31:0] ra, rb; int cyc;
    step();
    set_req(0, 1'b1, 32'h40, 32'hDEADBEEF, 4'b1111);
    wait_ack(aa, ab, ra, rb, cyc);
    checks++; if (cyc !== 2) begin fails++; $display("[TB] FAIL write_full_latency: got %0d expected 2", cyc); end
    checks++; if (aa !== 4'b0001) begin fails++; $display("[TB] FAIL write_full_ack_a: got %b expected 0001", aa); end
    checks++; if (ab !== 4'b0001) begin fails++; $display("[TB] FAIL write_full_ack_b: got %b expected 0001", ab); end
    step();
    clr_req(0);
  endtask

  task automatic test_single_read();
    step();
    set_req(2, 1'b0, 32'h40, 32'h0, 4'b1111);
    @(negedge clk);
    checks++; if (bus_a.s_cyc !== 1'b0) begin fails++; $display("[TB] FAIL read_c0_s_cyc: got %b expected 0", bus_a.s_cyc); end
    checks++; if (bus_a.m_rdt !== 32'h0) begin fails++; $display("[TB] FAIL read_c0_rdt: got %h expected 0", bus_a.m_rdt); end
    @(negedge clk);
    checks++; if (bus_a.s_cyc !== 1'b1) begin fails++; $display("[TB] FAIL read_c1_s_cyc: got %b expected 1", bus_a.s_cyc); end
    checks++; if (bus_a.s_adr !== 32'h40) begin fails++; $display("[TB] FAIL read_c1_s_adr: got %h expected 40", bus_a.s_adr); end
    checks++; if (grant_a !== 4'b0100) begin fails++; $display("[TB] FAIL read_c1_grant: got %b expected 0100", grant_a); end
    checks++; if (bus_a.m_ack !== 4'b0) begin fails++; $display("[TB] FAIL read_c1_ack: got %b expected 0000", bus_a.m_ack); end
    @(negedge clk);
    checks++; if (bus_a.m_ack !== 4'b0100) begin fails++; $display("[TB] FAIL read_c2_ack: got %b expected 0100", bus_a.m_ack); end
    checks++; if (bus_a.m_rdt !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL read_c2_rdt: got %h expected deadbeef", bus_a.m_rdt); end
    step();
    clr_req(2);
  endtask

  task automatic test_write_byte();
    logic [3:0] aa, ab; logic [31:0] ra, rb; int cyc;
    step();
    set_req(1, 1'b1, 32'h40, 32'h0000AB00, 4'b0010);
    wait_ack(aa, ab, ra, rb, cyc);
    checks++; if (aa !== 4'b0010) begin fails++; $display("[TB] FAIL wbyte_ack: got %b expected 0010", aa); end
    checks++; if (cyc !== 2) begin fails++; $display("[TB] FAIL wbyte_latency: got %0d expected 2", cyc); end
    step();
    clr_req(1);
    step();
    set_req(3, 1'b0, 32'h40, 32'h0, 4'b1111);
    wait_ack(aa, ab, ra, rb, cyc);
    checks++; if (aa !== 4'b1000) begin fails++; $display("[TB] FAIL readback_ack: got %b expected 1000", aa); end
    checks++; if (ra !== 32'hDEADABEF) begin fails++; $display("[TB] FAIL readback_rdt_a: got %h expected deadabef", ra); end
    checks++; if (rb !== 32'hDEADABEF) begin fails++; $display("[TB] FAIL readback_rdt_b: got %h expected deadabef", rb); end
    step();
    clr_req(3);
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq_a [5];
    logic [3:0] seq_b [5];
    logic [3:0] exp_a [5];
    int na, nb;
    logic saw3_b;
    exp_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin seq_a[i] = '0; seq_b[i] = '0; end
    na = 0; nb = 0; saw3_b = 1'b0;
    step();
    for (int p = 0; p < 4; p++) set_req(p, 1'b0, 32'h40, 32'h0, 4'b1111);
    for (int i = 0; i < 40 && na < 5; i++) begin
      @(negedge clk);
      if (grant_b == 4'b1000) saw3_b = 1'b1;
      if (bus_b.m_ack != 4'b0 && nb < 5) begin seq_b[nb] = bus_b.m_ack; nb++; end
      if (bus_a.m_ack != 4'b0) begin seq_a[na] = bus_a.m_ack; na++; end
    end
    checks++; if (na !== 5) begin fails++; $display("[TB] FAIL rr_ack_count: got %0d expected 5", na); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (seq_a[i] !== exp_a[i]) begin fails++; $display("[TB] FAIL rr_order[%0d]: got %b expected %b", i, seq_a[i], exp_a[i]); end
      checks++;
      if (seq_b[i] !== 4'b0001) begin fails++; $display("[TB] FAIL fixed_order[%0d]: got %b expected 0001", i, seq_b[i]); end
    end
    checks++; if (saw3_b !== 1'b0) begin fails++; $display("[TB] FAIL fixed_port3_granted: got %b expected 0", saw3_b); end
    step();
    for (int p = 0; p < 4; p++) clr_req(p);
  endtask

  task automatic test_timeout();
    logic [3:0] aa, ab, ea, eb, ka; logic [31:0] ra, rb; int cyc, first; logic sc;
    first = 0; ea = '0; eb = '0; ka = 'x; sc = 1'bx;
    ram_mute = 1'b1;
    step();
    set_req(1, 1'b0, 32'h80, 32'h0, 4'b1111);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus_a.m_err != 4'b0) begin
        first = i - 1; ea = bus_a.m_err; eb = bus_b.m_err; ka = bus_a.m_ack; sc = bus_a.s_cyc;
        break;
      end
    end
    checks++; if (first !== 15) begin fails++; $display("[TB] FAIL timeout_cycle: got %0d expected 15", first); end
    checks++; if (ea !== 4'b0010) begin fails++; $display("[TB] FAIL timeout_err_a: got %b expected 0010", ea); end
    checks++; if (eb !== 4'b0010) begin fails++; $display("[TB] FAIL timeout_err_b: got %b expected 0010", eb); end
    checks++; if (sc !== 1'b0) begin fails++; $display("[TB] FAIL timeout_s_cyc: got %b expected 0", sc); end
    checks++; if (ka !== 4'b0) begin fails++; $display("[TB] FAIL timeout_ack: got %b expected 0000", ka); end
    step();
    clr_req(1);
    ram_mute = 1'b0;
    @(negedge clk);
    checks++; if (grant_a !== 4'b0) begin fails++; $display("[TB] FAIL timeout_idle_grant: got %b expected 0000", grant_a); end
    checks++; if (bus_a.m_err !== 4'b0) begin fails++; $display("[TB] FAIL timeout_err_pulse: got %b expected 0000", bus_a.m_err); end
    step();
    set_req(3, 1'b0, 32'h40, 32'h0, 4'b1111);
    wait_ack(aa, ab, ra, rb, cyc);
    checks++; if (aa !== 4'b1000) begin fails++; $display("[TB] FAIL after_to_ack: got %b expected 1000", aa); end
    checks++; if (ra !== 32'hDEADABEF) begin fails++; $display("[TB] FAIL after_to_rdt: got %h expected deadabef", ra); end
    checks++; if (cyc !== 2) begin fails++; $display("[TB] FAIL after_to_latency: got %0d expected 2", cyc); end
    step();
    clr_req(3);
  endtask

  task automatic test_abort();
    logic [3:0] aa, ab; logic [31:0] ra, rb; int cyc;
    step();
    set_req(2, 1'b0, 32'h40, 32'h0, 4'b1111);
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus_a.s_cyc !== 1'b1) begin fails++; $display("[TB] FAIL abort_pre_s_cyc: got %b expected 1", bus_a.s_cyc); end
    #1 clr_req(2);
    #1;
    checks++; if (bus_a.s_cyc !== 1'b0) begin fails++; $display("[TB] FAIL abort_s_cyc: got %b expected 0", bus_a.s_cyc); end
    checks++; if ({bus_a.m_ack, bus_a.m_err} !== 8'h0) begin fails++; $display("[TB] FAIL abort_ack_err: got %b expected 0", {bus_a.m_ack, bus_a.m_err}); end
    @(negedge clk);
    checks++; if (grant_a !== 4'b0) begin fails++; $display("[TB] FAIL abort_idle_grant: got %b expected 0000", grant_a); end
    checks++; if (bus_a.m_ack !== 4'b0) begin fails++; $display("[TB] FAIL abort_no_ack: got %b expected 0000", bus_a.m_ack); end
    step();
    set_req(2, 1'b0, 32'h40, 32'h0, 4'b1111);
    set_req(3, 1'b0, 32'h40, 32'h0, 4'b1111);
    wait_ack(aa, ab, ra, rb, cyc);
    checks++; if (aa !== 4'b0100) begin fails++; $display("[TB] FAIL abort_rr_ptr: got %b expected 0100", aa); end
    checks++; if (ab !== 4'b0100) begin fails++; $display("[TB] FAIL abort_fixed: got %b expected 0100", ab); end
    step();
    clr_req(2);
    clr_req(3);
  endtask

  task automatic test_reset_busy();
    logic [3:0] aa, ab; logic [31:0] ra, rb; int cyc;
    step();
    set_req(1, 1'b1, 32'h100, 32'h12345678, 4'b1111);
    @(negedge clk);
    @(negedge clk);
    checks++; if (grant_a !== 4'b0010) begin fails++; $display("[TB] FAIL rbusy_grant: got %b expected 0010", grant_a); end
    checks++; if (bus_a.s_we !== 1'b1) begin fails++; $display("[TB] FAIL rbusy_s_we: got %b expected 1", bus_a.s_we); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({grant_a, bus_a.s_cyc, bus_a.s_we, bus_a.s_adr, bus_a.s_dat, bus_a.s_sel,
         bus_a.m_ack, bus_a.m_err, bus_a.m_rdt} !== '0) begin
      fails++; $display("[TB] FAIL rbusy_outputs_a: got grant=%b s_cyc=%b s_we=%b s_adr=%h s_dat=%h, expected all 0",
                        grant_a, bus_a.s_cyc, bus_a.s_we, bus_a.s_adr, bus_a.s_dat);
    end
    checks++;
    if ({grant_b, bus_b.s_cyc, bus_b.s_we, bus_b.s_adr, bus_b.s_dat} !== '0) begin
      fails++; $display("[TB] FAIL rbusy_outputs_b: got grant=%b s_cyc=%b, expected all 0", grant_b, bus_b.s_cyc);
    end
    #1;
    clr_req(1);
    rst = 1'b0;
    step();
    for (int p = 0; p < 4; p++) set_req(p, 1'b0, 32'h40, 32'h0, 4'b1111);
    wait_ack(aa, ab, ra, rb, cyc);
    checks++; if (aa !== 4'b0001) begin fails++; $display("[TB] FAIL post_reset_first: got %b expected 0001", aa); end
    checks++; if (ab !== 4'b0001) begin fails++; $display("[TB] FAIL post_reset_first_b: got %b expected 0001", ab); end
    checks++; if (cyc !== 2) begin fails++; $display("[TB] FAIL post_reset_latency: got %0d expected 2", cyc); end
    step();
    for (int p = 0; p < 4; p++) clr_req(p);
  endtask

  initial begin
    test_reset();
    test_write_full();
    test_single_read();
    test_write_byte();
    test_back_to_back();
    test_timeout();
    test_abort();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
